mprj_checkpoint_monitor: RTL

Synthesizable, parametrised checkpoint-sequence monitor for the user project area. It watches a WIDTH-bit slice of the mprj_io bus for an ordered list of up to DEPTH firmware signature codes (e.g. 16'hAB60 then 16'hAB61), with glitch filtering, a programmable fail code and a cycle timeout. It reports started/pass/fail/timeout status and progress on-chip, so smoke tests can run on silicon and under the logic analyzer, not only in a simulation bench.

---
 rtl/mprj_checkpoint_monitor.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: watches a synchronized, glitch-filtered slice of mprj_io
// for an ordered list of signature codes and reports started/pass/fail/timeout/progress.
module mprj_checkpoint_monitor #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT_W     = 24
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           checkbits,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]           cfg_code,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic [WIDTH-1:0]           fail_code,
  input  logic [TIMEOUT_W-1:0]       timeout_limit,
  output logic                       started,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     step,
  output logic [TIMEOUT_W-1:0]       cycles,
  output logic [2:0]                 o_dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]     r_s1;
  logic [WIDTH-1:0]     r_s2;
  logic [CW-1:0]        r_stab;
  logic                 r_hit;
  logic [WIDTH-1:0]     r_hit_val;
  logic [WIDTH-1:0]     r_code [DEPTH];

  logic [SW-1:0]        r_step;
  logic [TIMEOUT_W-1:0] r_cycles;
  logic                 r_started;
  logic                 r_pass;
  logic                 r_fail;
  logic                 r_timeout;

  logic [SW-1:0]        w_len;
  logic [WIDTH-1:0]     w_exp_code;
  logic                 w_exp_match;
  logic                 w_fail_match;
  logic [TIMEOUT_W-1:0] w_cyc_inc;
  logic                 w_timeout_hit;
  logic [SW-1:0]        w_step_inc;
  logic                 w_last;

  logic [SW-1:0]        w_step_nxt;
  logic [TIMEOUT_W-1:0] w_cycles_nxt;
  logic                 w_started_nxt;
  logic                 w_pass_nxt;
  logic                 w_fail_nxt;
  logic                 w_timeout_nxt;

  // The stability counter restarts at 1 whenever s2 takes a new value and parks at
  // STABLE_CYCLES+1, so each stable episode produces exactly one hit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_stab    <= '0;
      r_hit     <= 1'b0;
      r_hit_val <= '0;
    end else begin
      r_s1      <= checkbits;
      r_s2      <= r_s1;
      if (r_s1 != r_s2) begin
        r_stab <= CW'(1);
      end else if (r_stab != CW'(STABLE_CYCLES + 1)) begin
        r_stab <= r_stab + CW'(1);
      end
      r_hit     <= (r_s1 == r_s2) && (r_stab == CW'(STABLE_CYCLES));
      r_hit_val <= r_s2;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_code[i] <= '0;
      end
    end else if (cfg_we) begin
      r_code[cfg_idx] <= cfg_code;
    end
  end

  always_comb begin
    if (cfg_len == '0) begin
      w_len = SW'(1);
    end else if (cfg_len > SW'(DEPTH)) begin
      w_len = SW'(DEPTH);
    end else begin
      w_len = cfg_len;
    end
  end

  // Slots are read live, so a write to the awaited slot applies to the very next hit.
  assign w_exp_code    = r_code[r_step[IW-1:0]];
  assign w_exp_match   = r_hit && (r_hit_val == w_exp_code);
  assign w_fail_match  = r_hit && (r_hit_val == fail_code);
  assign w_cyc_inc     = (&r_cycles) ? r_cycles : r_cycles + TIMEOUT_W'(1);
  assign w_timeout_hit = (timeout_limit != '0) && (w_cyc_inc == timeout_limit);
  assign w_step_inc    = r_step + SW'(1);
  assign w_last        = (w_step_inc >= w_len);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Same-edge priority: enable low, then expected code, then fail code, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_ARMED;
      end
      S_ARMED, S_RUN: begin
        if (w_exp_match) begin
          w_state_nxt = w_last ? S_PASS : S_RUN;
        end else if (w_fail_match || w_timeout_hit) begin
          w_state_nxt = S_FAIL;
        end
      end
      S_PASS, S_FAIL: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_step_nxt    = r_step;
    w_cycles_nxt  = r_cycles;
    w_started_nxt = r_started;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_ARMED, S_RUN: begin
        w_cycles_nxt = w_cyc_inc;
        if (w_exp_match) begin
          w_step_nxt    = w_step_inc;
          w_started_nxt = 1'b1;
          w_pass_nxt    = w_last;
        end else if (w_fail_match) begin
          w_fail_nxt = 1'b1;
        end else if (w_timeout_hit) begin
          w_fail_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
        end
      end
      S_PASS, S_FAIL: begin
        w_step_nxt = r_step;
      end
      default: begin
        w_step_nxt    = '0;
        w_cycles_nxt  = '0;
        w_started_nxt = 1'b0;
        w_pass_nxt    = 1'b0;
        w_fail_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
      end
    endcase
    if (!enable) begin
      w_step_nxt    = '0;
      w_cycles_nxt  = '0;
      w_started_nxt = 1'b0;
      w_pass_nxt    = 1'b0;
      w_fail_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_step    <= '0;
      r_cycles  <= '0;
      r_started <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_step    <= w_step_nxt;
      r_cycles  <= w_cycles_nxt;
      r_started <= w_started_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign started     = r_started;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign step        = r_step;
  assign cycles      = r_cycles;
  assign o_dbg_state = r_state;

endmodule
